// File: rtl/tone_pkg.sv
// Shared types for the tone sample generator: FSM state codes
// and the full-scale amplitude helper.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Largest positive two's-complement value of a given width.
  function automatic int amp_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/tone_sample_gen_sync.sv
// Multi-flop synchronizer for one asynchronous level signal.
// Ports: i_clk, i_rst (async, active-high), i_d (async in), o_q (synced).
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/tone_sample_gen.sv
// Click-free square-wave sample generator driven by a note clock.
// Ports: CLOCK_50, reset (async, active-high), tone_clk, enable,
//   vol_shift, sample_ready -> audio_data, sample_valid,
//   overrun_cnt, state_dbg.
module tone_sample_gen
  import tone_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RAMP_STEP   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1048576
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tone_clk,
  input  logic             enable,
  input  logic [2:0]       vol_shift,
  input  logic             sample_ready,
  output logic [WIDTH-1:0] audio_data,
  output logic             sample_valid,
  output logic [7:0]       overrun_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] AMP_MAX =
    WIDTH'(amp_max(WIDTH));
  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  logic w_tone_s;
  logic w_en;
  logic w_edge;
  logic w_timeout;
  logic w_load;
  logic w_phase_n;
  logic [WIDTH-1:0] w_amp_n;
  logic [WIDTH:0]   w_up;
  logic [WIDTH-1:0] w_up_sat;
  logic [WIDTH-1:0] w_dn_sat;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_sample;
  state_t w_state_n;

  logic r_tone_prev;
  logic r_phase;
  logic r_valid;
  logic [WIDTH-1:0] r_amp;
  logic [WIDTH-1:0] r_audio;
  logic [7:0]       r_ovr;
  logic [TW-1:0]    r_tcnt;
  state_t r_state;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tone (
    .i_clk (CLOCK_50),
    .i_rst (reset),
    .i_d   (tone_clk),
    .o_q   (w_tone_s)
  );

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .i_clk (CLOCK_50),
    .i_rst (reset),
    .i_d   (enable),
    .o_q   (w_en)
  );

  assign w_edge = w_tone_s & ~r_tone_prev;

  assign w_timeout = (r_state != IDLE) && (r_tcnt >= TO_VAL);

  assign w_up     = {1'b0, r_amp} + STEP;
  assign w_up_sat = (w_up >= {1'b0, AMP_MAX}) ?
                    AMP_MAX : w_up[WIDTH-1:0];
  assign w_dn_sat = ({1'b0, r_amp} <= STEP) ?
                    '0 : r_amp - STEP[WIDTH-1:0];

  always_comb begin
    w_state_n = r_state;
    w_amp_n   = r_amp;
    w_phase_n = r_phase;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // First step of a new note always starts on the + half.
        if (w_en && w_edge) begin
          w_load    = 1'b1;
          w_phase_n = 1'b1;
          w_amp_n   = w_up_sat;
          w_state_n = (w_up_sat == AMP_MAX) ? PLAY : RAMP_UP;
        end
      end
      default: begin
        if (w_en) begin
          w_state_n = (r_state == RAMP_DOWN) ? RAMP_UP : r_state;
          if (w_edge) begin
            w_load    = 1'b1;
            w_phase_n = ~r_phase;
            if (r_state != PLAY) begin
              w_amp_n = w_up_sat;
              if (w_up_sat == AMP_MAX) w_state_n = PLAY;
            end
          end
        end else begin
          w_state_n = RAMP_DOWN;
          if (w_edge) begin
            w_load    = 1'b1;
            w_phase_n = ~r_phase;
            w_amp_n   = w_dn_sat;
            if (w_dn_sat == '0) w_state_n = IDLE;
          end
        end
      end
    endcase
    // A stalled note clock silences the output outright.
    if (w_timeout) begin
      w_state_n = IDLE;
      w_amp_n   = '0;
      w_phase_n = 1'b0;
      w_load    = 1'b0;
    end
  end

  always_comb begin
    w_mag = '0;
    if ({29'd0, vol_shift} < 32'(WIDTH - 1)) begin
      w_mag = w_amp_n >> vol_shift;
    end
    w_sample = w_phase_n ? w_mag : (~w_mag + 1'b1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tone_prev <= 1'b0;
      r_state     <= IDLE;
      r_amp       <= '0;
      r_phase     <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      r_tone_prev <= w_tone_s;
      r_state     <= w_state_n;
      r_amp       <= w_amp_n;
      r_phase     <= w_phase_n;
      if (w_edge || r_state == IDLE) begin
        r_tcnt <= '0;
      end else if (r_tcnt != TO_VAL) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_audio <= '0;
      r_valid <= 1'b0;
      r_ovr   <= '0;
    end else begin
      if (w_timeout) begin
        r_audio <= '0;
      end else if (w_load) begin
        r_audio <= w_sample;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        // Only a sample lost without being accepted counts.
        if (r_valid && !sample_ready && r_ovr != 8'hFF) begin
          r_ovr <= r_ovr + 8'd1;
        end
      end else if (sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign audio_data   = r_audio;
  assign sample_valid = r_valid;
  assign overrun_cnt  = r_ovr;
  assign state_dbg    = r_state;

endmodule
